// File: rtl/pep_ks_body_ram.sv
// ============================================================================
// Module   : pep_ks_body_ram
// Purpose  : PID-indexed store for key-switch bodies and mean-correction terms.
//            Tracks per-PID completeness/parity, serves a fixed-latency
//            read port, and counts complete entries.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pep_ks_body_ram #(
  parameter int OP_W       = 32,
  parameter int CORR_W     = 8,
  parameter int PID_NB     = 64,
  parameter int PID_W      = $clog2(PID_NB),
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              boram_wr_en,
  input  logic [OP_W-1:0]   boram_data,
  input  logic [PID_W-1:0]  boram_pid,
  input  logic              boram_parity,
  input  logic              boram_corr_wr_en,
  input  logic [CORR_W-1:0] boram_corr_data,
  input  logic [PID_W-1:0]  boram_corr_pid,
  input  logic              mean_comp_en,
  input  logic              rd_en,
  input  logic [PID_W-1:0]  rd_pid,
  input  logic              rd_parity,
  input  logic              rd_consume,
  output logic              rd_avail,
  output logic              rd_hit,
  output logic [OP_W-1:0]   rd_body,
  output logic [CORR_W-1:0] rd_corr,
  output logic [PID_W:0]    occupancy,
  output logic              err_ovf,
  output logic              err_miss
);

  localparam logic [PID_W:0] c_pid_nb = PID_NB[PID_W:0];

  // Data arrays carry no reset; only the flags decide what is valid.
  logic [OP_W-1:0]   r_body_mem [PID_NB];
  logic [CORR_W-1:0] r_corr_mem [PID_NB];

  logic [PID_NB-1:0] r_bvld;
  logic [PID_NB-1:0] r_cvld;
  logic [PID_NB-1:0] r_par;
  logic [PID_W:0]    r_occ;
  logic              r_err_ovf;

  logic              r_p_vld  [RD_LATENCY];
  logic              r_p_hit  [RD_LATENCY];
  logic [OP_W-1:0]   r_p_body [RD_LATENCY];
  logic [CORR_W-1:0] r_p_corr [RD_LATENCY];

  logic              w_rd_hit;
  logic              w_clr;
  logic              w_ovf;
  logic signed [PID_W+2:0] w_d_wr;
  logic signed [PID_W+2:0] w_d_cr;
  logic signed [PID_W+2:0] w_d_rd;
  logic signed [PID_W+2:0] w_occ_sum;
  logic [PID_W:0]    w_occ_nxt;

  // An entry is complete once the body is in and, under mean compensation,
  // the correction too.
  function automatic logic f_full(input logic b, input logic c, input logic mce);
    return b & (c | ~mce);
  endfunction

  // Change in completeness of one PID given which events touch it this cycle.
  // Writes take priority over a consuming clear.
  function automatic logic signed [PID_W+2:0] f_delta(input logic cb, input logic cc,
                                                     input logic hw, input logic hc,
                                                     input logic hr, input logic mce);
    logic fc;
    logic fn;
    fc = f_full(cb, cc, mce);
    fn = f_full(hw | (cb & ~hr), hc | (cc & ~hr), mce);
    if (fn && !fc)      return {{(PID_W+2){1'b0}}, 1'b1};
    else if (!fn && fc) return '1;
    else                return '0;
  endfunction

  // Read hit is decided on the flags as they stand before this cycle's writes.
  always_comb begin
    w_rd_hit = f_full(r_bvld[rd_pid], r_cvld[rd_pid], mean_comp_en)
               & (r_par[rd_pid] == rd_parity);
    w_clr    = rd_en & rd_consume & w_rd_hit;
    w_ovf    = (boram_wr_en & r_bvld[boram_pid]) | (boram_corr_wr_en & r_cvld[boram_corr_pid]);
  end

  // Occupancy delta: each distinct touched PID contributes once, then clamp.
  always_comb begin
    w_d_wr = '0;
    w_d_cr = '0;
    w_d_rd = '0;
    if (boram_wr_en)
      w_d_wr = f_delta(r_bvld[boram_pid], r_cvld[boram_pid], 1'b1,
                       boram_corr_wr_en & (boram_corr_pid == boram_pid),
                       w_clr & (rd_pid == boram_pid), mean_comp_en);
    if (boram_corr_wr_en && !(boram_wr_en && (boram_corr_pid == boram_pid)))
      w_d_cr = f_delta(r_bvld[boram_corr_pid], r_cvld[boram_corr_pid], 1'b0, 1'b1,
                       w_clr & (rd_pid == boram_corr_pid), mean_comp_en);
    if (w_clr && !(boram_wr_en && (rd_pid == boram_pid))
              && !(boram_corr_wr_en && (rd_pid == boram_corr_pid)))
      w_d_rd = f_delta(r_bvld[rd_pid], r_cvld[rd_pid], 1'b0, 1'b0, 1'b1, mean_comp_en);
    w_occ_sum = $signed({2'b00, r_occ}) + w_d_wr + w_d_cr + w_d_rd;
    if (w_occ_sum[PID_W+2])
      w_occ_nxt = '0;
    else if (w_occ_sum[PID_W+1:0] > {1'b0, c_pid_nb})
      w_occ_nxt = c_pid_nb;
    else
      w_occ_nxt = w_occ_sum[PID_W:0];
  end

  // Data array writes (no reset).
  always_ff @(posedge clk) begin
    if (boram_wr_en)      r_body_mem[boram_pid]      <= boram_data;
    if (boram_corr_wr_en) r_corr_mem[boram_corr_pid] <= boram_corr_data;
  end

  // Per-PID flags, occupancy and overflow flag; later assignments (writes) win
  // over the consuming clear of the same PID.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_bvld    <= '0;
      r_cvld    <= '0;
      r_par     <= '0;
      r_occ     <= '0;
      r_err_ovf <= 1'b0;
    end else begin
      if (w_clr) begin
        r_bvld[rd_pid] <= 1'b0;
        r_cvld[rd_pid] <= 1'b0;
        r_par[rd_pid]  <= 1'b0;
      end
      if (boram_wr_en) begin
        r_bvld[boram_pid] <= 1'b1;
        r_par[boram_pid]  <= boram_parity;
      end
      if (boram_corr_wr_en)
        r_cvld[boram_corr_pid] <= 1'b1;
      r_occ     <= w_occ_nxt;
      r_err_ovf <= w_ovf;
    end
  end

  // Fixed-latency read pipeline; reset drops everything in flight.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_p_vld[i]  <= 1'b0;
        r_p_hit[i]  <= 1'b0;
        r_p_body[i] <= '0;
        r_p_corr[i] <= '0;
      end
    end else begin
      r_p_vld[0]  <= rd_en;
      r_p_hit[0]  <= w_rd_hit;
      r_p_body[0] <= r_body_mem[rd_pid];
      r_p_corr[0] <= mean_comp_en ? r_corr_mem[rd_pid] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_p_vld[i]  <= r_p_vld[i-1];
        r_p_hit[i]  <= r_p_hit[i-1];
        r_p_body[i] <= r_p_body[i-1];
        r_p_corr[i] <= r_p_corr[i-1];
      end
    end
  end

  assign rd_avail  = r_p_vld[RD_LATENCY-1];
  assign rd_hit    = r_p_vld[RD_LATENCY-1] & r_p_hit[RD_LATENCY-1];
  assign err_miss  = r_p_vld[RD_LATENCY-1] & ~r_p_hit[RD_LATENCY-1];
  assign rd_body   = r_p_body[RD_LATENCY-1];
  assign rd_corr   = r_p_corr[RD_LATENCY-1];
  assign occupancy = r_occ;
  assign err_ovf   = r_err_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pep_ks_body_ram.sv
// ============================================================================
// Module   : tb_pep_ks_body_ram
// Purpose  : Self-checking bench for pep_ks_body_ram: directed scenarios plus
//            randomized traffic against a per-PID reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pep_ks_body_ram;

  localparam int OP_W = 32;
  localparam int CORR_W = 8;
  localparam int PID_NB = 64;
  localparam int PID_W = 6;
  localparam int RDL = 2;

  logic              clk = 1'b0;
  logic              a_rst = 1'b1;
  logic              boram_wr_en = 1'b0;
  logic [OP_W-1:0]   boram_data = '0;
  logic [PID_W-1:0]  boram_pid = '0;
  logic              boram_parity = 1'b0;
  logic              boram_corr_wr_en = 1'b0;
  logic [CORR_W-1:0] boram_corr_data = '0;
  logic [PID_W-1:0]  boram_corr_pid = '0;
  logic              mean_comp_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [PID_W-1:0]  rd_pid = '0;
  logic              rd_parity = 1'b0;
  logic              rd_consume = 1'b0;
  logic              rd_avail;
  logic              rd_hit;
  logic [OP_W-1:0]   rd_body;
  logic [CORR_W-1:0] rd_corr;
  logic [PID_W:0]    occupancy;
  logic              err_ovf;
  logic              err_miss;

  pep_ks_body_ram #(
    .OP_W(OP_W), .CORR_W(CORR_W), .PID_NB(PID_NB), .PID_W(PID_W), .RD_LATENCY(RDL)
  ) u_dut (
    .clk(clk), .a_rst(a_rst),
    .boram_wr_en(boram_wr_en), .boram_data(boram_data), .boram_pid(boram_pid),
    .boram_parity(boram_parity),
    .boram_corr_wr_en(boram_corr_wr_en), .boram_corr_data(boram_corr_data),
    .boram_corr_pid(boram_corr_pid), .mean_comp_en(mean_comp_en),
    .rd_en(rd_en), .rd_pid(rd_pid), .rd_parity(rd_parity), .rd_consume(rd_consume),
    .rd_avail(rd_avail), .rd_hit(rd_hit), .rd_body(rd_body), .rd_corr(rd_corr),
    .occupancy(occupancy), .err_ovf(err_ovf), .err_miss(err_miss)
  );

  always #5 clk = ~clk;

  // Reference model: what each PID holds, plus the reads still in flight.
  typedef struct {
    bit          vld;
    bit          hit;
    bit          bk;
    bit          ck;
    logic [31:0] body;
    logic [7:0]  corr;
  } exp_t;

  bit          m_b   [PID_NB];
  bit          m_c   [PID_NB];
  bit          m_p   [PID_NB];
  bit          m_bk  [PID_NB];
  bit          m_ck  [PID_NB];
  logic [31:0] m_body[PID_NB];
  logic [7:0]  m_corr[PID_NB];
  bit          mce;
  exp_t        exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit m_full(input int p);
    return m_b[p] && (m_c[p] || !mce);
  endfunction

  function automatic int count_full();
    int n = 0;
    for (int p = 0; p < PID_NB; p++) if (m_full(p)) n++;
    return n;
  endfunction

  // One clock cycle of stimulus; model updated, outputs checked #1 after the edge.
  task automatic step(input bit wr, input int wpid, input logic [31:0] wdata, input bit wpar,
                      input bit cwr, input int cpid, input logic [7:0] cdata,
                      input bit rd, input int rpid, input bit rpar, input bit cons);
    exp_t e;
    exp_t o;
    bit   novf;
    boram_wr_en = wr; boram_pid = wpid[PID_W-1:0]; boram_data = wdata; boram_parity = wpar;
    boram_corr_wr_en = cwr; boram_corr_pid = cpid[PID_W-1:0]; boram_corr_data = cdata;
    rd_en = rd; rd_pid = rpid[PID_W-1:0]; rd_parity = rpar; rd_consume = cons;
    e.vld  = rd;
    e.hit  = m_full(rpid) && (m_p[rpid] == rpar);
    e.bk   = m_bk[rpid];
    e.body = m_body[rpid];
    e.ck   = !mce || m_ck[rpid];
    e.corr = mce ? m_corr[rpid] : 8'h00;
    exp_q.push_back(e);
    novf = (wr && m_b[wpid]) || (cwr && m_c[cpid]);
    if (rd && cons && e.hit) begin
      m_b[rpid] = 0; m_c[rpid] = 0; m_p[rpid] = 0;
    end
    if (wr) begin
      m_b[wpid] = 1; m_p[wpid] = wpar; m_body[wpid] = wdata; m_bk[wpid] = 1;
    end
    if (cwr) begin
      m_c[cpid] = 1; m_corr[cpid] = cdata; m_ck[cpid] = 1;
    end
    @(posedge clk); #1;
    boram_wr_en = 0; boram_corr_wr_en = 0; rd_en = 0; rd_consume = 0;
    check("occ", occupancy, count_full());
    check("ovf", err_ovf, novf);
    o = '{default: 0};
    if (exp_q.size() == RDL) o = exp_q.pop_front();
    check("avail", rd_avail, o.vld);
    check("hit", rd_hit, o.vld && o.hit);
    check("miss", err_miss, o.vld && !o.hit);
    if (o.vld && o.bk) check("body", rd_body, o.body);
    if (o.vld && o.ck) check("corr", rd_corr, o.corr);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr_body(input int p, input logic [31:0] d, input bit par);
    step(1, p, d, par, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr_corr(input int p, input logic [7:0] d);
    step(0, 0, 0, 0, 1, p, d, 0, 0, 0, 0);
  endtask
  task automatic rd(input int p, input bit par, input bit cons);
    step(0, 0, 0, 0, 0, 0, 0, 1, p, par, cons);
  endtask

  // Asynchronous reset asserted mid-cycle; data arrays survive, flags do not.
  task automatic do_reset(input bit new_mce);
    @(negedge clk);
    a_rst = 1'b1;
    #1;
    check("rst_avail", rd_avail, 0);
    check("rst_occ", occupancy, 0);
    check("rst_miss", err_miss, 0);
    check("rst_ovf", err_ovf, 0);
    for (int p = 0; p < PID_NB; p++) begin
      m_b[p] = 0; m_c[p] = 0; m_p[p] = 0;
    end
    exp_q.delete();
    mce = new_mce;
    mean_comp_en = new_mce;
    @(negedge clk);
    a_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    mce = 0;
    for (int p = 0; p < PID_NB; p++) begin
      m_bk[p] = 0; m_ck[p] = 0; m_body[p] = '0; m_corr[p] = '0;
    end

    // Single entry, consumed
    do_reset(0);
    wr_body(5, 32'h1234, 1);
    rd(5, 1, 1);
    check("dir_occ_after_consume", occupancy, 0);
    idle();
    check("dir_single_avail", rd_avail, 1);
    check("dir_single_hit", rd_hit, 1);
    check("dir_single_body", rd_body, 32'h1234);

    // Parity mismatch
    wr_body(5, 32'h1234, 0);
    rd(5, 1, 1);
    idle();
    check("dir_par_miss", err_miss, 1);
    check("dir_par_hit", rd_hit, 0);
    check("dir_par_body", rd_body, 32'h1234);
    check("dir_par_occ", occupancy, 1);

    // Mean compensation
    do_reset(1);
    wr_body(7, 32'hABCD, 1);
    idle();
    check("dir_mc_occ_body_only", occupancy, 0);
    wr_corr(7, 8'h07);
    check("dir_mc_occ_full", occupancy, 1);
    rd(7, 1, 1);
    idle();
    check("dir_mc_hit", rd_hit, 1);
    check("dir_mc_corr", rd_corr, 8'h07);

    // Overflow
    do_reset(0);
    wr_body(3, 32'h1111, 0);
    wr_body(3, 32'h2222, 0);
    check("dir_ovf_pulse", err_ovf, 1);
    check("dir_ovf_occ", occupancy, 1);
    rd(3, 0, 0);
    idle();
    check("dir_ovf_body", rd_body, 32'h2222);

    // Same-cycle write/read race
    do_reset(0);
    step(1, 9, 32'h9999, 1, 0, 0, 0, 1, 9, 1, 1);
    rd(9, 1, 1);
    check("dir_race_miss", err_miss, 1);
    idle();
    check("dir_race_hit", rd_hit, 1);

    // Reset with reads in flight
    wr_body(2, 32'h2222_0002, 1);
    rd(2, 1, 0);
    rd(2, 1, 0);
    do_reset(0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("dir_rst_no_avail", rd_avail, 0);
    end
    rd(2, 1, 0);
    idle();
    check("dir_rst_flags_cleared", err_miss, 1);

    // Randomized traffic, a few phases with different mean_comp_en
    for (int ph = 0; ph < 4; ph++) begin
      do_reset(ph[0]);
      for (int i = 0; i < 300; i++) begin
        int rng;
        if (i == 150) do_reset(mce);
        rng = (ph == 3) ? PID_NB - 1 : 7;
        step($urandom_range(0, 2) == 0, $urandom_range(0, rng), $urandom, $urandom_range(0, 1),
             $urandom_range(0, 2) == 0, $urandom_range(0, rng), 8'($urandom),
             $urandom_range(0, 1) == 0, $urandom_range(0, rng), $urandom_range(0, 1),
             $urandom_range(0, 3) != 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
